// File: rtl/csram_responder_if.sv
// Grid, programming and readout bundle of the core SRAM responder.
// The master side is the neuron grid plus the host/router programming port;
// the slave side is the responder itself.
`timescale 1ns/1ps

interface csram_responder_if #(
  parameter int ADDR_WIDTH      = 8,
  parameter int NUM_AXONS       = 256,
  parameter int ROW_WIDTH       = 368,
  parameter int POTENTIAL_WIDTH = 9
);

  // Grid addressing and potential write-back
  logic [ADDR_WIDTH-1:0]      neuron_num;
  logic                       update_potential;
  logic [POTENTIAL_WIDTH-1:0] potential_in;

  // Row programming port
  logic                       prog_req;
  logic [ADDR_WIDTH-1:0]      prog_addr;
  logic [ROW_WIDTH-1:0]       prog_data;
  logic                       prog_ack;

  // Status
  logic                       ready;
  logic                       wr_err;

  // Registered row fields
  logic [NUM_AXONS-1:0]       synapses;
  logic [POTENTIAL_WIDTH-1:0] current_potential;
  logic [POTENTIAL_WIDTH-1:0] reset_potential;
  logic [35:0]                weights;
  logic [POTENTIAL_WIDTH-1:0] leak;
  logic [POTENTIAL_WIDTH-1:0] positive_threshold;
  logic [POTENTIAL_WIDTH-1:0] negative_threshold;
  logic                       reset_mode;
  logic [29:0]                route_info;

  modport master (
    output neuron_num, update_potential, potential_in,
    output prog_req, prog_addr, prog_data,
    input  prog_ack, ready, wr_err,
    input  synapses, current_potential, reset_potential, weights, leak,
    input  positive_threshold, negative_threshold, reset_mode, route_info
  );

  modport slave (
    input  neuron_num, update_potential, potential_in,
    input  prog_req, prog_addr, prog_data,
    output prog_ack, ready, wr_err,
    output synapses, current_potential, reset_potential, weights, leak,
    output positive_threshold, negative_threshold, reset_mode, route_info
  );

endinterface

// File: rtl/csram_responder.sv
// Core SRAM responder: 256 x 368-bit per-neuron parameter rows.
// Registered one-cycle read at neuron_num with same-cycle write forwarding,
// potential write-back from the grid, full-row programming from the host,
// and a post-reset sequencer that clears every row before going ready.
`timescale 1ns/1ps

module csram_responder #(
  parameter int NUM_NEURONS     = 256,
  parameter int NUM_AXONS       = 256,
  parameter int ROW_WIDTH       = 368,
  parameter int POTENTIAL_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  csram_responder_if.slave   bus
);

  localparam int ADDR_W = $clog2(NUM_NEURONS);

  // Row field layout, MSB to LSB
  localparam int SYN_LSB   = 112;
  localparam int POT_LSB   = 103;
  localparam int RPOT_LSB  = 94;
  localparam int WGT_LSB   = 58;
  localparam int LEAK_LSB  = 49;
  localparam int PTH_LSB   = 40;
  localparam int NTH_LSB   = 31;
  localparam int RMODE_BIT = 30;
  localparam int POT_MSB   = POT_LSB + POTENTIAL_WIDTH - 1;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_NEURONS - 1);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     init_cnt, cnt_d;

  logic [ROW_WIDTH-1:0]  mem [NUM_NEURONS];
  logic [ROW_WIDTH-1:0]  rd_q, rd_d;

  logic                  init_we, grid_we, prog_we;
  logic                  prog_ack_d, wr_err_d;
  logic                  prog_ack_q, wr_err_q;

  logic                  nn_ok, pa_ok;
  logic [ADDR_W-1:0]     nn_idx, pa_idx;

  // Out-of-range rows only exist when the array is smaller than the 8-bit address space
  assign nn_ok  = (32'(bus.neuron_num) < NUM_NEURONS);
  assign pa_ok  = (32'(bus.prog_addr)  < NUM_NEURONS);
  assign nn_idx = ADDR_W'(bus.neuron_num);
  assign pa_idx = ADDR_W'(bus.prog_addr);

  // State, init counter, registered read row and status pulses
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt   <= '0;
      rd_q       <= '0;
      prog_ack_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt   <= cnt_d;
      rd_q       <= rd_d;
      prog_ack_q <= prog_ack_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Next state, write arbitration (init > grid > program) and forwarded read data
  // NOTE: every signal gets a default first so no path through this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = init_cnt;
    init_we    = 1'b0;
    grid_we    = 1'b0;
    prog_we    = 1'b0;
    prog_ack_d = 1'b0;
    wr_err_d   = 1'b0;
    rd_d       = '0;

    unique case (state_q)
      INIT: begin
        // Clear one row per cycle; grid writes are rejected, programming is held off
        init_we  = 1'b1;
        cnt_d    = init_cnt + 1'b1;
        wr_err_d = bus.update_potential;
        if (init_cnt == LAST_ROW) begin
          state_d = READY;
        end
      end

      READY: begin
        if (bus.update_potential) begin
          // Grid write-back always wins the single write port
          if (nn_ok) begin
            grid_we = 1'b1;
          end else begin
            wr_err_d = 1'b1;
          end
        end else if (bus.prog_req) begin
          // Out-of-range program rows are acked but dropped so the host never hangs
          prog_ack_d = 1'b1;
          prog_we    = pa_ok;
        end

        if (nn_ok) begin
          rd_d = mem[nn_idx];
        end
        // Forward this cycle's write so the registered read never returns stale data
        if (grid_we) begin
          rd_d[POT_MSB:POT_LSB] = bus.potential_in;
        end else if (prog_we && (bus.prog_addr == bus.neuron_num)) begin
          rd_d = bus.prog_data;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Row array write port
  // NOTE: the array has no reset; the init sequencer clears it and reads are masked until ready.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (grid_we) begin
      mem[nn_idx][POT_MSB:POT_LSB] <= bus.potential_in;
    end else if (prog_we) begin
      mem[pa_idx] <= bus.prog_data;
    end
  end

  assign bus.ready    = (state_q == READY);
  assign bus.prog_ack = prog_ack_q;
  assign bus.wr_err   = wr_err_q;

  assign bus.synapses           = rd_q[ROW_WIDTH-1 -: NUM_AXONS];
  assign bus.current_potential  = rd_q[POT_MSB:POT_LSB];
  assign bus.reset_potential    = rd_q[RPOT_LSB +: POTENTIAL_WIDTH];
  assign bus.weights            = rd_q[SYN_LSB-POTENTIAL_WIDTH-POTENTIAL_WIDTH-1 -: 36];
  assign bus.leak               = rd_q[LEAK_LSB +: POTENTIAL_WIDTH];
  assign bus.positive_threshold = rd_q[PTH_LSB +: POTENTIAL_WIDTH];
  assign bus.negative_threshold = rd_q[NTH_LSB +: POTENTIAL_WIDTH];
  assign bus.reset_mode         = rd_q[RMODE_BIT];
  assign bus.route_info         = rd_q[RMODE_BIT-1:0];

  // WGT_LSB documents the layout; the weights slice is anchored from its MSB above
  logic unused_layout;
  assign unused_layout = (WGT_LSB == 58);

endmodule

// File: tb/tb_csram_responder.sv
// Directed bench for csram_responder: init timing, early writes, programming,
// write-back with forwarding, grid/program collision and mid-operation reset.
`timescale 1ns/1ps

module tb_csram_responder;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  csram_responder_if bus ();

  csram_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [367:0] obs_row;
  assign obs_row = {bus.synapses, bus.current_potential, bus.reset_potential,
                    bus.weights, bus.leak, bus.positive_threshold,
                    bus.negative_threshold, bus.reset_mode, bus.route_info};

  task automatic check(input string tag, input logic [367:0] obs, input logic [367:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [367:0] row_a, row_b, row_c, row_d;
  int bad_rows;

  initial begin
    checks = 0;
    errors = 0;

    row_a = '0;
    row_a[367:112] = '1;
    row_a[111:103] = 9'h010;
    row_a[57:49]   = 9'h1FF;
    row_a[30]      = 1'b1;
    row_a[29:0]    = 30'h155;

    row_b = '0;
    row_b[111:103] = 9'h055;
    row_b[93:58]   = 36'hABCDE1234;
    row_b[29:0]    = 30'h3000_0001;

    row_c = '0;
    row_c[48:40]   = 9'h0F0;
    row_c[29:0]    = 30'h99;

    row_d = '0;
    row_d[367:300] = '1;
    row_d[102:94]  = 9'h12C;
    row_d[29:0]    = 30'h234_5678;

    rst_n                = 1'b0;
    bus.neuron_num       = '0;
    bus.update_potential = 1'b0;
    bus.potential_in     = '0;
    bus.prog_req         = 1'b0;
    bus.prog_addr        = '0;
    bus.prog_data        = '0;

    // Reset state
    repeat (3) tick();
    check("reset_ready", 368'(bus.ready), 368'(1'b0));
    check("reset_fields", obs_row, '0);
    check("reset_pulses", 368'({bus.prog_ack, bus.wr_err}), 368'(2'b00));

    // Release reset just after an edge; the next edge is init edge 1
    rst_n = 1'b1;
    repeat (9) tick();

    // Early write and program request during INIT (edge 10)
    bus.neuron_num       = 8'd3;
    bus.update_potential = 1'b1;
    bus.potential_in     = 9'h1AB;
    bus.prog_req         = 1'b1;
    bus.prog_addr        = 8'd3;
    bus.prog_data        = '1;
    tick();
    check("init_wr_err_pulse", 368'(bus.wr_err), 368'(1'b1));
    check("init_no_ack", 368'(bus.prog_ack), 368'(1'b0));
    check("init_read_zero", obs_row, '0);

    bus.update_potential = 1'b0;
    tick();  // edge 11
    check("init_wr_err_single", 368'(bus.wr_err), 368'(1'b0));
    check("init_no_ack_2", 368'(bus.prog_ack), 368'(1'b0));
    bus.prog_req = 1'b0;

    repeat (244) tick();  // edge 255
    check("ready_low_edge255", 368'(bus.ready), 368'(1'b0));
    tick();               // edge 256
    check("ready_high_edge256", 368'(bus.ready), 368'(1'b1));

    // Every row reads back cleared, including row 3 hit by the early write
    bad_rows = 0;
    for (int i = 0; i < 256; i++) begin
      bus.neuron_num = 8'(i);
      tick();
      if (obs_row !== '0) bad_rows++;
    end
    check("all_rows_zero", 368'(bad_rows), 368'(0));

    // Program row 5 and read it back
    bus.neuron_num = 8'd0;
    bus.prog_req   = 1'b1;
    bus.prog_addr  = 8'd5;
    bus.prog_data  = row_a;
    tick();
    check("prog5_ack", 368'(bus.prog_ack), 368'(1'b1));
    bus.prog_req   = 1'b0;
    bus.neuron_num = 8'd5;
    tick();
    check("prog5_ack_drop", 368'(bus.prog_ack), 368'(1'b0));
    check("prog5_synapses", 368'(bus.synapses), {112'd0, {256{1'b1}}});
    check("prog5_potential", 368'(bus.current_potential), 368'(9'h010));
    check("prog5_leak", 368'(bus.leak), 368'(9'h1FF));
    check("prog5_reset_mode", 368'(bus.reset_mode), 368'(1'b1));
    check("prog5_route", 368'(bus.route_info), 368'(30'h155));
    check("prog5_weights", 368'(bus.weights), 368'(36'h0));

    // Write-back to row 5 with same-cycle forwarding
    bus.update_potential = 1'b1;
    bus.potential_in     = 9'h0A3;
    tick();
    check("wb_forward_potential", 368'(bus.current_potential), 368'(9'h0A3));
    check("wb_forward_leak", 368'(bus.leak), 368'(9'h1FF));
    check("wb_no_err", 368'(bus.wr_err), 368'(1'b0));
    bus.update_potential = 1'b0;
    bus.neuron_num       = 8'd0;
    tick();
    bus.neuron_num = 8'd5;
    tick();
    check("wb_stored_potential", 368'(bus.current_potential), 368'(9'h0A3));
    check("wb_stored_synapses", 368'(bus.synapses), {112'd0, {256{1'b1}}});
    check("wb_stored_leak", 368'(bus.leak), 368'(9'h1FF));
    check("wb_stored_route", 368'(bus.route_info), 368'(30'h155));

    // Program forwarding: program row 6 while reading row 6
    bus.neuron_num = 8'd6;
    bus.prog_req   = 1'b1;
    bus.prog_addr  = 8'd6;
    bus.prog_data  = row_d;
    tick();
    check("prog6_ack", 368'(bus.prog_ack), 368'(1'b1));
    check("prog6_forward_row", obs_row, row_d);
    bus.prog_req = 1'b0;

    // Collision on row 7: grid wins, program retries next cycle
    bus.neuron_num       = 8'd7;
    bus.update_potential = 1'b1;
    bus.potential_in     = 9'h077;
    bus.prog_req         = 1'b1;
    bus.prog_addr        = 8'd7;
    bus.prog_data        = row_b;
    tick();
    check("coll_no_ack", 368'(bus.prog_ack), 368'(1'b0));
    check("coll_grid_potential", 368'(bus.current_potential), 368'(9'h077));
    check("coll_weights_old", 368'(bus.weights), 368'(36'h0));
    bus.update_potential = 1'b0;
    tick();
    check("coll_retry_ack", 368'(bus.prog_ack), 368'(1'b1));
    check("coll_retry_forward", obs_row, row_b);
    bus.prog_req   = 1'b0;
    bus.neuron_num = 8'd0;
    tick();
    check("coll_ack_single", 368'(bus.prog_ack), 368'(1'b0));
    bus.neuron_num = 8'd7;
    tick();
    check("coll_final_row", obs_row, row_b);

    // Program row 9, then reset in the middle of a pending request
    bus.neuron_num = 8'd0;
    bus.prog_req   = 1'b1;
    bus.prog_addr  = 8'd9;
    bus.prog_data  = row_c;
    tick();
    check("prog9_ack", 368'(bus.prog_ack), 368'(1'b1));
    bus.prog_req   = 1'b0;
    bus.neuron_num = 8'd9;
    tick();
    check("prog9_readback", obs_row, row_c);

    bus.prog_req  = 1'b1;
    bus.prog_data = '1;
    rst_n         = 1'b0;
    #1;
    check("midrst_ready", 368'(bus.ready), 368'(1'b0));
    check("midrst_fields", obs_row, '0);
    check("midrst_no_ack", 368'(bus.prog_ack), 368'(1'b0));
    tick();
    bus.prog_req = 1'b0;
    rst_n        = 1'b1;
    repeat (255) tick();
    check("reinit_ready_low", 368'(bus.ready), 368'(1'b0));
    check("reinit_no_ack", 368'(bus.prog_ack), 368'(1'b0));
    tick();
    check("reinit_ready_high", 368'(bus.ready), 368'(1'b1));
    tick();
    check("reinit_row9_zero", obs_row, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
